// File: rtl/sdram_arbiter_pkg.sv
// Shared types and constants for the SDRAM client arbiter.
package sdram_pkg;
    localparam int SDRAM_ADDR_W = 26;
    localparam int LINE_WORDS   = 16;

    typedef logic [2:0] master_id_t;

    typedef struct packed {
        logic [SDRAM_ADDR_W-1:0] address;
        logic                    write;
        logic                    burst;
        logic [31:0]             wdata;
        logic [3:0]              wmask;
    } sdram_cmd_t;
endpackage

// File: rtl/sdram_arbiter_if.sv
// SDRAM command/response port; N lanes of command signals, shared read-return bus.
interface sdram_arbiter_if import sdram_pkg::*; #(parameter int N = 1);
    logic [N-1:0]                   request;
    logic [N-1:0]                   ready;
    logic [N-1:0][SDRAM_ADDR_W-1:0] address;
    logic [N-1:0]                   write;
    logic [N-1:0]                   burst;
    logic [N-1:0][31:0]             wdata;
    logic [N-1:0][3:0]              wmask;
    logic [N-1:0]                   rvalid;
    logic [31:0]                    rdata;
    logic [SDRAM_ADDR_W-1:0]        raddress;
    logic                           complete;

    modport master (output request, address, write, burst, wdata, wmask,
                    input  ready, rvalid, rdata, raddress, complete);
    modport slave  (input  request, address, write, burst, wdata, wmask,
                    output ready, rvalid, rdata, raddress, complete);
endinterface

// File: rtl/sdram_arbiter_id_fifo.sv
// In-order FIFO of master IDs for reads that are still waiting on data.
module arb_id_fifo import sdram_pkg::*; #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       push,
    input  master_id_t push_id,
    input  logic       pop,
    output logic       full,
    output logic       empty,
    output master_id_t head
);
    localparam int AW = $clog2(DEPTH);

    master_id_t    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          do_push, do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointers are AW bits wide, so they wrap for free at DEPTH.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_id;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/sdram_arbiter.sv
// Round-robin SDRAM client arbiter with a one-entry command register and
// in-order read-return routing.
module sdram_arbiter import sdram_pkg::*; #(
    parameter int NUM_MASTERS = 3,
    parameter int ID_DEPTH    = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    sdram_arbiter_if.slave   m,
    sdram_arbiter_if.master  sd,
    output logic             err_orphan
);
    logic [NUM_MASTERS-1:0] eligible, grant, head_oh;
    master_id_t             ptr, winner, head;
    logic                   found, cmd_free, accept, push, pop, full, empty;
    int                     best_d, d;
    sdram_cmd_t             cmd;

    assign pop      = sd.rvalid[0] && sd.complete && !empty;
    assign cmd_free = !sd.request[0] || sd.ready[0];

    // A read may take the last FIFO slot only if a slot frees this cycle.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_MASTERS; i++)
            eligible[i] = m.request[i] && (m.write[i] || !full || pop);
    end

    // Rotate-priority find-first: distance 0 is the master right after ptr.
    always_comb begin
        found  = 1'b0;
        winner = ptr;
        best_d = NUM_MASTERS;
        d      = 0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            d = (i + NUM_MASTERS - 1 - int'(ptr)) % NUM_MASTERS;
            if (eligible[i] && d < best_d) begin
                best_d = d;
                found  = 1'b1;
                winner = master_id_t'(i);
            end
        end
    end

    always_comb begin
        grant   = '0;
        head_oh = '0;
        cmd     = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            grant[i]   = cmd_free && found && (winner == master_id_t'(i));
            head_oh[i] = (head == master_id_t'(i));
            if (winner == master_id_t'(i))
                cmd = '{address: m.address[i], write: m.write[i], burst: m.burst[i],
                        wdata: m.wdata[i], wmask: m.wmask[i]};
        end
    end

    assign m.ready = grant;
    assign accept  = |grant;
    assign push    = accept && !cmd.write;

    arb_id_fifo #(.DEPTH(ID_DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .push_id (winner),
        .pop     (pop),
        .full    (full),
        .empty   (empty),
        .head    (head)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sd.request <= '0;
            sd.address <= '0;
            sd.write   <= '0;
            sd.burst   <= '0;
            sd.wdata   <= '0;
            sd.wmask   <= '0;
            ptr        <= master_id_t'(NUM_MASTERS - 1);
            m.rvalid   <= '0;
            m.rdata    <= '0;
            m.raddress <= '0;
            m.complete <= 1'b0;
            err_orphan <= 1'b0;
        end else begin
            if (accept) begin
                sd.request[0] <= 1'b1;
                sd.address[0] <= cmd.address;
                sd.write[0]   <= cmd.write;
                sd.burst[0]   <= cmd.burst;
                sd.wdata[0]   <= cmd.wdata;
                sd.wmask[0]   <= cmd.wmask;
                ptr           <= winner;
            end else if (sd.ready[0]) begin
                sd.request[0] <= 1'b0;
            end

            // Beats with no outstanding read are dropped and flagged.
            m.rvalid <= '0;
            if (sd.rvalid[0]) begin
                if (empty) begin
                    err_orphan <= 1'b1;
                end else begin
                    m.rvalid   <= head_oh;
                    m.rdata    <= sd.rdata;
                    m.raddress <= sd.raddress;
                    m.complete <= sd.complete;
                end
            end
        end
    end
endmodule

// File: tb/tb_sdram_arbiter.sv
// Scoreboard bench for sdram_arbiter: grants, stalls, FIFO-full, routing, reset.
module tb_sdram_arbiter;
    import sdram_pkg::*;
    localparam int N = 3;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic err_orphan;

    sdram_arbiter_if #(.N(N)) m_bus();
    sdram_arbiter_if #(.N(1)) sd_bus();

    sdram_arbiter #(.NUM_MASTERS(N), .ID_DEPTH(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .m          (m_bus),
        .sd         (sd_bus),
        .err_orphan (err_orphan)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [31:0] data;
        logic [25:0] addr;
        logic        cmp;
    } beat_t;

    beat_t sb[$];
    int    gq[$];
    int    rcv[N];
    int    n_chk = 0;
    int    n_fail = 0;
    beat_t mon_e;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [N-1:0] oh(input int id);
        logic [N-1:0] v;
        v = '0;
        v[id] = 1'b1;
        return v;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic set_m(input int i, input logic req, input logic wr, input logic bu,
                         input logic [25:0] a, input logic [31:0] dat);
        m_bus.request[i] = req;
        m_bus.write[i]   = wr;
        m_bus.burst[i]   = bu;
        m_bus.address[i] = a;
        m_bus.wdata[i]   = dat;
        m_bus.wmask[i]   = 4'hF;
    endtask

    // Controller model: n consecutive beats; expected ones go to the scoreboard.
    task automatic drive_beats(input int n, input logic [25:0] base, input logic last_cmp,
                               input int exp_id, input logic expect_it);
        beat_t e;
        for (int b = 0; b < n; b++) begin
            cyc();
            sd_bus.rvalid   = 1'b1;
            sd_bus.raddress = base + 26'(b * 4);
            sd_bus.rdata    = $urandom;
            sd_bus.complete = last_cmp && (b == n - 1);
            if (expect_it) begin
                e = '{id: exp_id, data: sd_bus.rdata, addr: sd_bus.raddress, cmp: sd_bus.complete};
                sb.push_back(e);
            end
        end
        cyc();
        sd_bus.rvalid   = 1'b0;
        sd_bus.complete = 1'b0;
    endtask

    always @(negedge clk) begin
        if (|m_bus.rvalid) begin
            if (sb.size() == 0) begin
                chk("stray_rvalid", 64'(m_bus.rvalid), 64'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("rv_route", 64'(m_bus.rvalid), 64'(oh(mon_e.id)));
                chk("rv_data", 64'(m_bus.rdata), 64'(mon_e.data));
                chk("rv_addr", 64'(m_bus.raddress), 64'(mon_e.addr));
                chk("rv_complete", 64'(m_bus.complete), 64'(mon_e.cmp));
                for (int i = 0; i < N; i++) if (m_bus.rvalid[i]) rcv[i]++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g, s0, s1;
        for (int i = 0; i < N; i++) begin
            set_m(i, 1'b0, 1'b0, 1'b0, '0, '0);
            rcv[i] = 0;
        end
        sd_bus.ready    = 1'b1;
        sd_bus.rvalid   = 1'b0;
        sd_bus.raddress = '0;
        sd_bus.rdata    = '0;
        sd_bus.complete = 1'b0;
        repeat (3) @(posedge clk);
        at_neg();
        chk("rst_m_ready", 64'(m_bus.ready), 64'd0);
        chk("rst_m_rvalid", 64'(m_bus.rvalid), 64'd0);
        chk("rst_sd_request", 64'(sd_bus.request), 64'd0);
        chk("rst_err_orphan", 64'(err_orphan), 64'd0);
        chk("rst_sd_address", 64'(sd_bus.address), 64'd0);
        chk("rst_m_rdata", 64'(m_bus.rdata), 64'd0);
        cyc();
        reset_n = 1'b1;

        // 1: single burst read
        cyc();
        set_m(0, 1'b1, 1'b0, 1'b1, 26'h40, '0);
        at_neg();
        chk("t1_grant", 64'(m_bus.ready), 64'(3'b001));
        cyc();
        set_m(0, 1'b0, 1'b0, 1'b0, '0, '0);
        at_neg();
        chk("t1_sd_request", 64'(sd_bus.request), 64'd1);
        chk("t1_sd_burst", 64'(sd_bus.burst), 64'd1);
        chk("t1_sd_address", 64'(sd_bus.address), 64'h40);
        chk("t1_sd_write", 64'(sd_bus.write), 64'd0);
        drive_beats(16, 26'h40, 1'b1, 0, 1'b1);
        repeat (2) at_neg();
        chk("t1_sb_drained", 64'(sb.size()), 64'd0);
        chk("t1_beats", 64'(rcv[0]), 64'd16);
        chk("t1_fifo_empty", 64'(dut.u_fifo.empty), 64'd1);

        // 2: round robin from a fresh pointer
        cyc();
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        cyc();
        for (int i = 0; i < N; i++) set_m(i, 1'b1, 1'b0, 1'b0, 26'(i * 'h100), '0);
        gq.push_back(0); gq.push_back(1); gq.push_back(2); gq.push_back(0);
        repeat (4) begin
            at_neg();
            g = gq.pop_front();
            chk("t2_grant", 64'(m_bus.ready), 64'(oh(g)));
            cyc();
        end

        // 3: FIFO full blocks reads, not writes; a pop frees a slot same cycle
        at_neg();
        chk("t3_full_block", 64'(m_bus.ready), 64'd0);
        cyc();
        set_m(0, 1'b0, 1'b0, 1'b0, '0, '0);
        set_m(2, 1'b1, 1'b1, 1'b0, 26'h200, 32'hA5A5A5A5);
        at_neg();
        chk("t3_write_ok", 64'(m_bus.ready), 64'(3'b100));
        cyc();
        set_m(2, 1'b0, 1'b0, 1'b0, '0, '0);
        at_neg();
        chk("t3_still_full", 64'(m_bus.ready), 64'd0);
        chk("t3_sd_write", 64'(sd_bus.write), 64'd1);
        cyc();
        sd_bus.rvalid   = 1'b1;
        sd_bus.complete = 1'b1;
        sd_bus.raddress = 26'h0;
        sd_bus.rdata    = 32'h0BADF00D;
        sb.push_back('{id: 0, data: 32'h0BADF00D, addr: 26'h0, cmp: 1'b1});
        at_neg();
        chk("t3_pop_accept", 64'(m_bus.ready), 64'(3'b010));
        cyc();
        sd_bus.rvalid   = 1'b0;
        sd_bus.complete = 1'b0;
        set_m(1, 1'b0, 1'b0, 1'b0, '0, '0);
        drive_beats(1, 26'h100, 1'b1, 1, 1'b1);
        drive_beats(1, 26'h200, 1'b1, 2, 1'b1);
        drive_beats(1, 26'h000, 1'b1, 0, 1'b1);
        drive_beats(1, 26'h100, 1'b1, 1, 1'b1);
        repeat (2) at_neg();
        chk("t3_sb_drained", 64'(sb.size()), 64'd0);
        chk("t3_fifo_empty", 64'(dut.u_fifo.empty), 64'd1);

        // 4: controller stall holds the command register
        cyc();
        sd_bus.ready = 1'b0;
        set_m(0, 1'b1, 1'b1, 1'b0, 26'h1234560, 32'hDEADBEEF);
        at_neg();
        chk("t4_grant", 64'(m_bus.ready), 64'(3'b001));
        cyc();
        set_m(0, 1'b0, 1'b0, 1'b0, '0, '0);
        set_m(1, 1'b1, 1'b1, 1'b0, 26'h100, 32'h55);
        repeat (5) begin
            at_neg();
            chk("t4_hold_req", 64'(sd_bus.request), 64'd1);
            chk("t4_hold_addr", 64'(sd_bus.address), 64'h1234560);
            chk("t4_hold_wdata", 64'(sd_bus.wdata), 64'hDEADBEEF);
            chk("t4_no_ready", 64'(m_bus.ready), 64'd0);
            cyc();
        end
        sd_bus.ready = 1'b1;
        at_neg();
        chk("t4_release_grant", 64'(m_bus.ready), 64'(3'b010));
        cyc();
        set_m(1, 1'b0, 1'b0, 1'b0, '0, '0);
        at_neg();
        chk("t4_next_addr", 64'(sd_bus.address), 64'h100);
        chk("t4_next_wdata", 64'(sd_bus.wdata), 64'h55);

        // 5: write accepted while a burst returns
        cyc();
        set_m(0, 1'b1, 1'b0, 1'b1, 26'h800, '0);
        at_neg();
        chk("t5_read_grant", 64'(m_bus.ready), 64'(3'b001));
        cyc();
        set_m(0, 1'b0, 1'b0, 1'b0, '0, '0);
        s0 = rcv[0];
        s1 = rcv[1];
        fork
            drive_beats(16, 26'h800, 1'b1, 0, 1'b1);
            begin
                repeat (5) cyc();
                set_m(1, 1'b1, 1'b1, 1'b0, 26'h300, 32'h1234);
                at_neg();
                chk("t5_write_grant", 64'(m_bus.ready), 64'(3'b010));
                cyc();
                set_m(1, 1'b0, 1'b0, 1'b0, '0, '0);
            end
        join
        repeat (2) at_neg();
        chk("t5_sb_drained", 64'(sb.size()), 64'd0);
        chk("t5_m0_beats", 64'(rcv[0] - s0), 64'd16);
        chk("t5_m1_none", 64'(rcv[1] - s1), 64'd0);

        // 6: reset mid-burst, leftover beats become orphans
        cyc();
        set_m(0, 1'b1, 1'b0, 1'b1, 26'h1000, '0);
        at_neg();
        chk("t6_grant", 64'(m_bus.ready), 64'(3'b001));
        cyc();
        set_m(0, 1'b0, 1'b0, 1'b0, '0, '0);
        s0 = rcv[0];
        drive_beats(8, 26'h1000, 1'b0, 0, 1'b1);
        at_neg();
        #2 reset_n = 1'b0;
        #1;
        chk("t6_rst_m_ready", 64'(m_bus.ready), 64'd0);
        chk("t6_rst_m_rvalid", 64'(m_bus.rvalid), 64'd0);
        chk("t6_rst_sd_request", 64'(sd_bus.request), 64'd0);
        chk("t6_rst_err_orphan", 64'(err_orphan), 64'd0);
        chk("t6_rst_m_rdata", 64'(m_bus.rdata), 64'd0);
        chk("t6_rst_m_complete", 64'(m_bus.complete), 64'd0);
        chk("t6_first_half", 64'(rcv[0] - s0), 64'd8);
        cyc();
        reset_n = 1'b1;
        drive_beats(8, 26'h1020, 1'b1, 0, 1'b0);
        repeat (2) at_neg();
        chk("t6_err_orphan", 64'(err_orphan), 64'd1);
        chk("t6_no_more_beats", 64'(rcv[0] - s0), 64'd8);
        chk("t6_sb_drained", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
